// File: rtl/snake_motion_unit.sv
// Snake body storage and stepping: moves one cell per step tick in PLAY, flags wall/body hits,
// and answers registered per-cell occupancy queries for the display path.
module snake_motion_unit #(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int MAX_LEN     = 16,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int INIT_X      = 20,
  parameter int INIT_Y      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_status,
  input  logic       key0_right,
  input  logic       key1_left,
  input  logic       key2_down,
  input  logic       key3_up,
  input  logic       food_eaten,
  input  logic [5:0] query_x,
  input  logic [4:0] query_y,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] snake_len,
  output logic       move_tick,
  output logic       hit_wall,
  output logic       hit_body,
  output logic       query_head,
  output logic       query_body
);

  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_START   = 2'b01;
  localparam logic [1:0] GS_PLAY    = 2'b10;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  localparam int               CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [6:0]       GRID_W7  = 7'(GRID_W);
  localparam logic [5:0]       GRID_H6  = 6'(GRID_H);
  localparam logic [5:0]       INIT_X6  = 6'(INIT_X);
  localparam logic [4:0]       INIT_Y5  = 5'(INIT_Y);
  localparam logic [4:0]       MAX_LEN5 = 5'(MAX_LEN);

  logic [5:0]       seg_x [MAX_LEN];
  logic [4:0]       seg_y [MAX_LEN];
  logic [4:0]       len;
  logic [1:0]       dir, next_dir;
  logic [CNT_W-1:0] step_cnt;
  logic             grow_pending;
  logic [3:0]       key_s, key_d;

  logic [3:0] press;
  logic       press_vld, press_ok;
  logic [1:0] press_dir;
  logic       grow_now, at_last, out_of_grid, into_body;
  logic [6:0] new_x;
  logic [5:0] new_y;
  logic [4:0] body_lim;
  logic       q_head_hit, q_body_hit;

  // Keys are active-low: a press is the 1->0 edge between the two sample stages.
  assign press = key_d & ~key_s;

  always_comb begin
    press_vld = 1'b1;
    press_dir = DIR_RIGHT;
    if (press[3])      press_dir = DIR_UP;
    else if (press[2]) press_dir = DIR_DOWN;
    else if (press[1]) press_dir = DIR_LEFT;
    else if (press[0]) press_dir = DIR_RIGHT;
    else               press_vld = 1'b0;
  end

  // Opposite directions differ only in bit 0 of the encoding.
  assign press_ok = press_vld && (press_dir != (dir ^ 2'b01)) &&
                    (game_status == GS_START || game_status == GS_PLAY);

  assign grow_now = grow_pending | food_eaten;
  assign at_last  = (step_cnt == CNT_LAST);

  // One bit wider than the coordinate so that stepping below zero wraps to a huge value.
  always_comb begin
    new_x = {1'b0, seg_x[0]};
    new_y = {1'b0, seg_y[0]};
    case (next_dir)
      DIR_RIGHT: new_x = {1'b0, seg_x[0]} + 7'd1;
      DIR_LEFT:  new_x = {1'b0, seg_x[0]} - 7'd1;
      DIR_DOWN:  new_y = {1'b0, seg_y[0]} + 6'd1;
      default:   new_y = {1'b0, seg_y[0]} - 6'd1;
    endcase
  end

  assign out_of_grid = (new_x >= GRID_W7) || (new_y >= GRID_H6);

  // The tail vacates its cell on a normal step, so it only blocks when growing.
  always_comb begin
    body_lim  = grow_now ? len : len - 5'd1;
    into_body = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (5'(i) < body_lim && seg_x[i] == new_x[5:0] && seg_y[i] == new_y[4:0])
        into_body = 1'b1;
    end
  end

  always_comb begin
    q_head_hit = (seg_x[0] == query_x) && (seg_y[0] == query_y);
    q_body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (5'(i) < len && seg_x[i] == query_x && seg_y[i] == query_y)
        q_body_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_s <= 4'hF;
      key_d <= 4'hF;
    end else begin
      key_s <= {key3_up, key2_down, key1_left, key0_right};
      key_d <= key_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      query_head <= 1'b0;
      query_body <= 1'b0;
    end else begin
      query_head <= q_head_hit;
      query_body <= q_body_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || game_status == GS_RESTART || game_status == GS_START) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < 3) ? INIT_X6 - 6'(i) : 6'd0;
        seg_y[i] <= (i < 3) ? INIT_Y5 : 5'd0;
      end
      len          <= 5'd3;
      dir          <= DIR_RIGHT;
      step_cnt     <= '0;
      grow_pending <= 1'b0;
      hit_wall     <= 1'b0;
      hit_body     <= 1'b0;
      move_tick    <= 1'b0;
      // A direction chosen during START survives into PLAY.
      if (rst || game_status == GS_RESTART) next_dir <= DIR_RIGHT;
      else if (press_ok)                    next_dir <= press_dir;
    end else if (game_status == GS_PLAY) begin
      move_tick <= 1'b0;
      if (press_ok)   next_dir     <= press_dir;
      if (food_eaten) grow_pending <= 1'b1;
      if (!hit_wall && !hit_body) begin
        step_cnt <= at_last ? '0 : step_cnt + CNT_W'(1);
        if (at_last) begin
          if (out_of_grid) begin
            hit_wall <= 1'b1;
          end else if (into_body) begin
            hit_body <= 1'b1;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0]     <= new_x[5:0];
            seg_y[0]     <= new_y[4:0];
            dir          <= next_dir;
            move_tick    <= 1'b1;
            grow_pending <= 1'b0;
            if (grow_now && len < MAX_LEN5) len <= len + 5'd1;
          end
        end
      end
    end else begin
      move_tick <= 1'b0;
    end
  end

  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign snake_len = len;

endmodule
